pr_read_arbiter: RTL and testbench
==================================

Name: pr_read_arbiter

Overview:
- Shares the single AXI read-address/read-data port between the PageRank vertex fetcher (ID 0) and in-edge fetcher (ID 1).
- Weighted round-robin on AR; tags bursts with requester ID; steers R beats back by rid.
- Enforces a per-requester outstanding-burst limit so each requester's receive FIFO cannot overflow.
- Sits between the PageRank fetch state machine and the shell memory port.

Parameters:
- EDGE_WEIGHT, 4: max consecutive in-edge grants before the vertex stream is preferred (matches vertex:in-edge RATIO).
- MAX_OUTSTANDING, 4: max un-completed bursts per requester.
- CNT_W, 8: width of outstanding counters; must hold MAX_OUTSTANDING.
- ARSIZE, 3'b110: constant burst size driven on arsize_m.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- v_req_valid / v_req_ready  in / out  1  vertex read request handshake
- v_req_addr  in  64  byte address, 64B aligned
- v_req_len  in  8  AXI arlen
- ie_req_valid / ie_req_ready / ie_req_addr / ie_req_len  in/out/in/in  1/1/64/8  same, in-edge stream
- v_rsp_valid  out  1,  v_rsp_data  out  512,  v_rsp_last  out  1,  v_rsp_ready  in  1  vertex beat stream
- ie_rsp_valid / ie_rsp_data / ie_rsp_last / ie_rsp_ready  out/out/out/in  1/512/1/1  in-edge beat stream
- arid_m out 16, araddr_m out 64, arlen_m out 8, arsize_m out 3, arvalid_m out 1, arready_m in 1  AXI AR
- rid_m in 16, rdata_m in 512, rresp_m in 2, rlast_m in 1, rvalid_m in 1, rready_m out 1  AXI R
- v_outstanding / ie_outstanding  out  CNT_W  live outstanding-burst counts
- rresp_err  out  1  sticky: any beat with rresp_m != 0
- bad_id_err  out  1  sticky: beat with rid_m not 0 or 1
- idle  out  1  no arvalid pending and both counts zero

Behaviour:
- Reset (sync, rst=1 at posedge): arvalid_m=0, arid_m=0, araddr_m=0, arlen_m=0, counters=0, both errors=0, ie_run=EDGE_WEIGHT so vertex wins first. arsize_m is always ARSIZE. Reset mid-burst drops all tracking; the shell is reset alongside.
- AR slot free when !arvalid_m or (arvalid_m & arready_m).
- Eligibility: requester eligible when req_valid and its count < MAX_OUTSTANDING, counting a grant already sitting in the AR slot.
- Grant (combinational, one at most): both eligible -> ie if ie_run < EDGE_WEIGHT, else vertex; one eligible -> that one. x_req_ready = slot free & granted x.
- On accept: AR regs load {id, addr, len}, arvalid_m=1 next cycle (1-cycle latency). Vertex grant sets ie_run=0; ie grant sets ie_run=min(ie_run+1, EDGE_WEIGHT).
- AXI stability: AR fields hold unchanged while arvalid_m & !arready_m. Back-to-back issue every cycle when arready_m=1.
- Counters: increment on AR handshake for arid_m; decrement on rvalid_m & rready_m & rlast_m for rid_m. Increment and decrement on same ID same cycle leave the count unchanged. Never wraps.
- R steering (combinational):
  - rid 0 -> v_rsp_* = R fields, rready_m = v_rsp_ready.
  - rid 1 -> ie_rsp_* likewise.
  - Other rid -> rready_m=1, beat dropped, bad_id_err set.
  - The unselected rsp_valid is 0.
- rresp_err sets on any accepted beat with rresp_m != 0; data is still forwarded.
- idle = !arvalid_m & v_outstanding==0 & ie_outstanding==0.

Decomposition:
- Shared package/constants header: VERT_ID=0, IE_ID=1, ARSIZE_64B, AXI field widths.
- One natural sub-module: pr_wrr_grant (eligibility, weighted round-robin pick, ie_run counter).

Test Plan:
- Reset: assert rst 2 cycles with requests pending -> arvalid_m=0, counts 0, idle=1, no req_ready.
- Both requesting continuously, arready_m=1, EDGE_WEIGHT=4, rlast returned promptly -> arid_m sequence 0,1,1,1,1,0,1,1,1,1; addresses match each stream in order.
- arready_m low 3 cycles after arvalid_m -> araddr_m/arid_m/arlen_m constant; both req_ready=0; issue on cycle 4.
- MAX_OUTSTANDING=2, only vertex requesting, no R -> two ARs, then v_req_ready=0 and v_outstanding=2; ie request still granted. rid=0 rlast -> v_outstanding=1, next vertex AR issues.
- rid=1 beats with ie_rsp_ready=0 for 2 cycles -> rready_m=0, beat held; rid=5 beat -> rready_m=1, no rsp_valid, bad_id_err=1; rresp=2 -> rresp_err=1.
- Same-cycle AR handshake (id 1) and rlast (rid 1) with ie_outstanding=1 -> stays 1.

Source files
------------

// File: rtl/pr_read_arbiter_pkg.sv
// Shared constants and types for the PageRank read-port arbiter.
// Requester IDs, AXI field widths and the grant encoding live here so the
// top level and the grant logic agree on them.
package pr_read_arbiter_pkg;

    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 512;
    localparam int RESP_W = 2;
    localparam int SIZE_W = 3;

    localparam logic [ID_W-1:0]   VERT_ID    = 16'd0;
    localparam logic [ID_W-1:0]   IE_ID      = 16'd1;
    localparam logic [SIZE_W-1:0] ARSIZE_64B = 3'b110;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_VERT = 2'd1,
        GRANT_IE   = 2'd2
    } grant_e;

    // AXI ID carried by a burst granted to the given requester
    function automatic logic [ID_W-1:0] grant_to_id(input grant_e g);
        return (g == GRANT_IE) ? IE_ID : VERT_ID;
    endfunction

endpackage

// File: rtl/pr_wrr_grant.sv
// Weighted round-robin pick between the vertex and in-edge requesters.
// A requester is eligible only while its outstanding bursts, including one
// already parked in the AR slot, stay below the limit. The in-edge stream may
// take up to EDGE_WEIGHT grants in a row before the vertex stream is preferred.
import pr_read_arbiter_pkg::*;

module pr_wrr_grant #(
    parameter int EDGE_WEIGHT     = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_req_valid,
    input  logic             ie_req_valid,
    input  logic [CNT_W-1:0] v_count,
    input  logic [CNT_W-1:0] ie_count,
    input  logic             v_in_slot,
    input  logic             ie_in_slot,
    input  logic             slot_free,
    output grant_e           grant,
    output logic             accept,
    output logic             v_req_ready,
    output logic             ie_req_ready
);

    localparam int RUN_W = $clog2(EDGE_WEIGHT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(EDGE_WEIGHT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W:0]   MAX_LIM = (CNT_W + 1)'(MAX_OUTSTANDING);

    logic [RUN_W-1:0] ie_run;
    logic [CNT_W:0]   v_eff;
    logic [CNT_W:0]   ie_eff;
    logic             v_eligible;
    logic             ie_eligible;

    assign v_eff  = {1'b0, v_count}  + {{CNT_W{1'b0}}, v_in_slot};
    assign ie_eff = {1'b0, ie_count} + {{CNT_W{1'b0}}, ie_in_slot};

    assign v_eligible  = v_req_valid  & (v_eff  < MAX_LIM);
    assign ie_eligible = ie_req_valid & (ie_eff < MAX_LIM);

    // Pick at most one requester; in-edge wins ties until its run is used up
    always_comb begin
        grant = GRANT_NONE;
        if (v_eligible && ie_eligible) begin
            grant = (ie_run < RUN_MAX) ? GRANT_IE : GRANT_VERT;
        end else if (v_eligible) begin
            grant = GRANT_VERT;
        end else if (ie_eligible) begin
            grant = GRANT_IE;
        end
    end

    assign accept       = slot_free & ~rst & (grant != GRANT_NONE);
    assign v_req_ready  = accept & (grant == GRANT_VERT);
    assign ie_req_ready = accept & (grant == GRANT_IE);

    // Track consecutive in-edge grants; a vertex grant restarts the run
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_run <= RUN_MAX;
        end else if (accept) begin
            if (grant == GRANT_VERT) begin
                ie_run <= '0;
            end else if (ie_run < RUN_MAX) begin
                ie_run <= ie_run + RUN_ONE;
            end
        end
    end

endmodule

// File: rtl/pr_read_arbiter.sv
// Shares one AXI read port between the PageRank vertex fetcher (ID 0) and
// in-edge fetcher (ID 1). Bursts are tagged with the requester ID on AR and
// read beats are steered back by rid. Per-requester outstanding counts keep
// each requester's receive FIFO from overflowing.
import pr_read_arbiter_pkg::*;

module pr_read_arbiter #(
    parameter int                EDGE_WEIGHT     = 4,
    parameter int                MAX_OUTSTANDING = 4,
    parameter int                CNT_W           = 8,
    parameter logic [SIZE_W-1:0] ARSIZE          = ARSIZE_64B
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              v_req_valid,
    output logic              v_req_ready,
    input  logic [ADDR_W-1:0] v_req_addr,
    input  logic [LEN_W-1:0]  v_req_len,

    input  logic              ie_req_valid,
    output logic              ie_req_ready,
    input  logic [ADDR_W-1:0] ie_req_addr,
    input  logic [LEN_W-1:0]  ie_req_len,

    output logic              v_rsp_valid,
    output logic [DATA_W-1:0] v_rsp_data,
    output logic              v_rsp_last,
    input  logic              v_rsp_ready,

    output logic              ie_rsp_valid,
    output logic [DATA_W-1:0] ie_rsp_data,
    output logic              ie_rsp_last,
    input  logic              ie_rsp_ready,

    output logic [ID_W-1:0]   arid_m,
    output logic [ADDR_W-1:0] araddr_m,
    output logic [LEN_W-1:0]  arlen_m,
    output logic [SIZE_W-1:0] arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,

    input  logic [ID_W-1:0]   rid_m,
    input  logic [DATA_W-1:0] rdata_m,
    input  logic [RESP_W-1:0] rresp_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,

    output logic [CNT_W-1:0]  v_outstanding,
    output logic [CNT_W-1:0]  ie_outstanding,
    output logic              rresp_err,
    output logic              bad_id_err,
    output logic              idle
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    grant_e grant;
    logic   accept;
    logic   slot_free;
    logic   ar_hs;
    logic   r_hs;
    logic   v_in_slot;
    logic   ie_in_slot;
    logic   v_inc;
    logic   v_dec;
    logic   ie_inc;
    logic   ie_dec;

    assign slot_free  = ~arvalid_m | arready_m;
    assign ar_hs      = arvalid_m & arready_m;
    assign r_hs       = rvalid_m & rready_m;
    assign v_in_slot  = arvalid_m & (arid_m == VERT_ID);
    assign ie_in_slot = arvalid_m & (arid_m == IE_ID);

    assign v_inc  = ar_hs & (arid_m == VERT_ID);
    assign ie_inc = ar_hs & (arid_m == IE_ID);
    assign v_dec  = r_hs & rlast_m & (rid_m == VERT_ID);
    assign ie_dec = r_hs & rlast_m & (rid_m == IE_ID);

    assign arsize_m = ARSIZE;
    assign idle     = ~arvalid_m & (v_outstanding == '0) & (ie_outstanding == '0);

    pr_wrr_grant #(
        .EDGE_WEIGHT     (EDGE_WEIGHT),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_grant (
        .clk          (clk),
        .rst          (rst),
        .v_req_valid  (v_req_valid),
        .ie_req_valid (ie_req_valid),
        .v_count      (v_outstanding),
        .ie_count     (ie_outstanding),
        .v_in_slot    (v_in_slot),
        .ie_in_slot   (ie_in_slot),
        .slot_free    (slot_free),
        .grant        (grant),
        .accept       (accept),
        .v_req_ready  (v_req_ready),
        .ie_req_ready (ie_req_ready)
    );

    // AR slot: load the granted request, hold it stable until arready
    always_ff @(posedge clk) begin
        if (rst) begin
            arvalid_m <= 1'b0;
            arid_m    <= '0;
            araddr_m  <= '0;
            arlen_m   <= '0;
        end else if (accept) begin
            arvalid_m <= 1'b1;
            arid_m    <= grant_to_id(grant);
            araddr_m  <= (grant == GRANT_IE) ? ie_req_addr : v_req_addr;
            arlen_m   <= (grant == GRANT_IE) ? ie_req_len  : v_req_len;
        end else if (arready_m) begin
            arvalid_m <= 1'b0;
        end
    end

    // Outstanding bursts: up on AR issue, down on last beat, saturating both ways
    always_ff @(posedge clk) begin
        if (rst) begin
            v_outstanding  <= '0;
            ie_outstanding <= '0;
        end else begin
            case ({v_inc, v_dec})
                2'b10:   if (v_outstanding != CNT_MAX) v_outstanding <= v_outstanding + CNT_ONE;
                2'b01:   if (v_outstanding != '0)      v_outstanding <= v_outstanding - CNT_ONE;
                default: v_outstanding <= v_outstanding;
            endcase
            case ({ie_inc, ie_dec})
                2'b10:   if (ie_outstanding != CNT_MAX) ie_outstanding <= ie_outstanding + CNT_ONE;
                2'b01:   if (ie_outstanding != '0)      ie_outstanding <= ie_outstanding - CNT_ONE;
                default: ie_outstanding <= ie_outstanding;
            endcase
        end
    end

    // Steer each R beat to its owner by rid; unknown IDs are drained and dropped
    always_comb begin
        v_rsp_valid  = 1'b0;
        v_rsp_data   = rdata_m;
        v_rsp_last   = rlast_m;
        ie_rsp_valid = 1'b0;
        ie_rsp_data  = rdata_m;
        ie_rsp_last  = rlast_m;
        rready_m     = 1'b1;
        if (rid_m == VERT_ID) begin
            v_rsp_valid = rvalid_m;
            rready_m    = v_rsp_ready;
        end else if (rid_m == IE_ID) begin
            ie_rsp_valid = rvalid_m;
            rready_m     = ie_rsp_ready;
        end
    end

    // Sticky error flags for bad responses and stray IDs
    always_ff @(posedge clk) begin
        if (rst) begin
            rresp_err  <= 1'b0;
            bad_id_err <= 1'b0;
        end else if (r_hs) begin
            if (rresp_m != '0) begin
                rresp_err <= 1'b1;
            end
            if ((rid_m != VERT_ID) && (rid_m != IE_ID)) begin
                bad_id_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pr_read_arbiter.sv
// Directed bench for the PageRank read arbiter: reset, weighted round-robin
// order, AR stall stability, outstanding limit, R steering and error flags.
module tb_pr_read_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         v_req_valid, v_req_ready;
    logic [63:0]  v_req_addr;
    logic [7:0]   v_req_len;
    logic         ie_req_valid, ie_req_ready;
    logic [63:0]  ie_req_addr;
    logic [7:0]   ie_req_len;
    logic         v_rsp_valid, v_rsp_last, v_rsp_ready;
    logic [511:0] v_rsp_data;
    logic         ie_rsp_valid, ie_rsp_last, ie_rsp_ready;
    logic [511:0] ie_rsp_data;
    logic [15:0]  arid_m;
    logic [63:0]  araddr_m;
    logic [7:0]   arlen_m;
    logic [2:0]   arsize_m;
    logic         arvalid_m, arready_m;
    logic [15:0]  rid_m;
    logic [511:0] rdata_m;
    logic [1:0]   rresp_m;
    logic         rlast_m, rvalid_m, rready_m;
    logic [7:0]   v_outstanding, ie_outstanding;
    logic         rresp_err, bad_id_err, idle;

    logic         echo_mode;
    logic         rvalid_drv, rlast_drv;
    logic [15:0]  rid_drv;

    int check_count = 0;
    int error_count = 0;

    localparam logic [63:0]  V_BASE  = 64'h0000_0000_1000_0000;
    localparam logic [63:0]  IE_BASE = 64'h0000_0000_2000_0000;
    localparam logic [511:0] BEAT_A  = {8{64'hA5A5_0000_DEAD_BEEF}};

    // Echo mode answers every AR handshake with a single-beat R in the same cycle
    assign rvalid_m = echo_mode ? (arvalid_m & arready_m) : rvalid_drv;
    assign rid_m    = echo_mode ? arid_m : rid_drv;
    assign rlast_m  = echo_mode ? 1'b1 : rlast_drv;

    pr_read_arbiter #(
        .EDGE_WEIGHT     (4),
        .MAX_OUTSTANDING (2),
        .CNT_W           (8),
        .ARSIZE          (3'b110)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .v_req_valid    (v_req_valid),
        .v_req_ready    (v_req_ready),
        .v_req_addr     (v_req_addr),
        .v_req_len      (v_req_len),
        .ie_req_valid   (ie_req_valid),
        .ie_req_ready   (ie_req_ready),
        .ie_req_addr    (ie_req_addr),
        .ie_req_len     (ie_req_len),
        .v_rsp_valid    (v_rsp_valid),
        .v_rsp_data     (v_rsp_data),
        .v_rsp_last     (v_rsp_last),
        .v_rsp_ready    (v_rsp_ready),
        .ie_rsp_valid   (ie_rsp_valid),
        .ie_rsp_data    (ie_rsp_data),
        .ie_rsp_last    (ie_rsp_last),
        .ie_rsp_ready   (ie_rsp_ready),
        .arid_m         (arid_m),
        .araddr_m       (araddr_m),
        .arlen_m        (arlen_m),
        .arsize_m       (arsize_m),
        .arvalid_m      (arvalid_m),
        .arready_m      (arready_m),
        .rid_m          (rid_m),
        .rdata_m        (rdata_m),
        .rresp_m        (rresp_m),
        .rlast_m        (rlast_m),
        .rvalid_m       (rvalid_m),
        .rready_m       (rready_m),
        .v_outstanding  (v_outstanding),
        .ie_outstanding (ie_outstanding),
        .rresp_err      (rresp_err),
        .bad_id_err     (bad_id_err),
        .idle           (idle)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request side and AR ready, then let combinational outputs settle
    task automatic applyStimulus(input logic vv, input logic [63:0] va, input logic [7:0] vl,
                                 input logic iv, input logic [63:0] ia, input logic [7:0] il,
                                 input logic ar_rdy);
        v_req_valid  = vv;
        v_req_addr   = va;
        v_req_len    = vl;
        ie_req_valid = iv;
        ie_req_addr  = ia;
        ie_req_len   = il;
        arready_m    = ar_rdy;
        #1;
    endtask

    // Drive one R beat (not in echo mode), then let steering settle
    task automatic driveBeat(input logic valid, input logic [15:0] id, input logic last,
                             input logic [1:0] resp, input logic [511:0] data);
        rvalid_drv = valid;
        rid_drv    = id;
        rlast_drv  = last;
        rresp_m    = resp;
        rdata_m    = data;
        #1;
    endtask

    initial begin
        logic [15:0] exp_ids [10];
        logic [15:0] got_ids [10];
        logic [63:0] got_addr [10];
        logic [7:0]  got_len [10];
        int          n_rec;
        int          v_idx;
        int          ie_idx;
        int          exp_v;
        int          exp_ie;
        logic        v_acc;
        logic        ie_acc;

        exp_ids = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};

        rst          = 1'b1;
        echo_mode    = 1'b0;
        v_rsp_ready  = 1'b0;
        ie_rsp_ready = 1'b0;
        rvalid_drv   = 1'b0;
        rid_drv      = '0;
        rlast_drv    = 1'b0;
        rresp_m      = '0;
        rdata_m      = '0;
        applyStimulus(1'b1, V_BASE, 8'd3, 1'b1, IE_BASE, 8'd7, 1'b1);

        // Reset held two cycles with both requests pending
        tick();
        tick();
        #1;
        checkOutput("rst_arvalid", arvalid_m, 1'b0);
        checkOutput("rst_arid", arid_m, 16'd0);
        checkOutput("rst_araddr", araddr_m, 64'd0);
        checkOutput("rst_arlen", arlen_m, 8'd0);
        checkOutput("rst_arsize", arsize_m, 3'b110);
        checkOutput("rst_v_cnt", v_outstanding, 8'd0);
        checkOutput("rst_ie_cnt", ie_outstanding, 8'd0);
        checkOutput("rst_idle", idle, 1'b1);
        checkOutput("rst_v_ready", v_req_ready, 1'b0);
        checkOutput("rst_ie_ready", ie_req_ready, 1'b0);
        checkOutput("rst_errs", {rresp_err, bad_id_err}, 2'b00);
        rst = 1'b0;

        // Weighted round-robin with both streams busy and R echoed immediately
        echo_mode    = 1'b1;
        v_rsp_ready  = 1'b1;
        ie_rsp_ready = 1'b1;
        n_rec  = 0;
        v_idx  = 0;
        ie_idx = 0;
        for (int cyc = 0; cyc < 40 && n_rec < 10; cyc++) begin
            applyStimulus(1'b1, V_BASE + 64'(v_idx) * 64, 8'd3, 1'b1, IE_BASE + 64'(ie_idx) * 64, 8'd7, 1'b1);
            v_acc  = v_req_ready;
            ie_acc = ie_req_ready;
            if (arvalid_m && arready_m) begin
                got_ids[n_rec]  = arid_m;
                got_addr[n_rec] = araddr_m;
                got_len[n_rec]  = arlen_m;
                n_rec++;
            end
            tick();
            if (v_acc)  v_idx++;
            if (ie_acc) ie_idx++;
        end
        checkOutput("wrr_issue_count", n_rec, 10);
        exp_v  = 0;
        exp_ie = 0;
        for (int k = 0; k < n_rec; k++) begin
            checkOutput($sformatf("wrr_id%0d", k), got_ids[k], exp_ids[k]);
            if (exp_ids[k] == 16'd0) begin
                checkOutput($sformatf("wrr_addr%0d", k), got_addr[k], V_BASE + 64'(exp_v) * 64);
                checkOutput($sformatf("wrr_len%0d", k), got_len[k], 8'd3);
                exp_v++;
            end else begin
                checkOutput($sformatf("wrr_addr%0d", k), got_addr[k], IE_BASE + 64'(exp_ie) * 64);
                checkOutput($sformatf("wrr_len%0d", k), got_len[k], 8'd7);
                exp_ie++;
            end
        end

        // Drain the slot while echo still retires every burst
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        tick();
        tick();
        echo_mode = 1'b0;
        #1;
        checkOutput("drain_idle", idle, 1'b1);
        checkOutput("drain_v_cnt", v_outstanding, 8'd0);
        checkOutput("drain_ie_cnt", ie_outstanding, 8'd0);

        // AR stall: fields hold and no request is accepted while arready is low
        applyStimulus(1'b1, 64'h0000_0000_0000_ABC0, 8'd5, 1'b0, '0, '0, 1'b0);
        checkOutput("stall_accept", v_req_ready, 1'b1);
        tick();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, 64'h0000_0000_0000_BBC0, 8'd9, 1'b1, 64'h0000_0000_0000_CC00, 8'd2, 1'b0);
            checkOutput($sformatf("stall%0d_arvalid", s), arvalid_m, 1'b1);
            checkOutput($sformatf("stall%0d_arid", s), arid_m, 16'd0);
            checkOutput($sformatf("stall%0d_araddr", s), araddr_m, 64'h0000_0000_0000_ABC0);
            checkOutput($sformatf("stall%0d_arlen", s), arlen_m, 8'd5);
            checkOutput($sformatf("stall%0d_readys", s), {v_req_ready, ie_req_ready}, 2'b00);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("stall_issued", arvalid_m, 1'b0);
        checkOutput("stall_v_cnt", v_outstanding, 8'd1);

        // Outstanding limit of two for the vertex stream, no R returned
        applyStimulus(1'b1, 64'h0000_0000_0000_D000, 8'd1, 1'b0, '0, '0, 1'b1);
        checkOutput("lim_v_ready_first", v_req_ready, 1'b1);
        tick();
        checkOutput("lim_v_ready_slot", v_req_ready, 1'b0);
        tick();
        checkOutput("lim_v_cnt2", v_outstanding, 8'd2);
        checkOutput("lim_v_ready_full", v_req_ready, 1'b0);
        applyStimulus(1'b1, 64'h0000_0000_0000_D040, 8'd1, 1'b1, 64'h0000_0000_0000_E000, 8'd4, 1'b1);
        checkOutput("lim_ie_ready", ie_req_ready, 1'b1);
        tick();
        applyStimulus(1'b1, 64'h0000_0000_0000_D040, 8'd1, 1'b0, '0, '0, 1'b1);
        checkOutput("lim_ie_arid", arid_m, 16'd1);
        checkOutput("lim_ie_araddr", araddr_m, 64'h0000_0000_0000_E000);
        tick();
        checkOutput("lim_ie_cnt", ie_outstanding, 8'd1);
        checkOutput("lim_v_still_blocked", v_req_ready, 1'b0);

        // Vertex last beat frees one slot and lets the next vertex AR through
        v_rsp_ready = 1'b1;
        driveBeat(1'b1, 16'd0, 1'b1, 2'd0, BEAT_A);
        checkOutput("r0_v_valid", v_rsp_valid, 1'b1);
        checkOutput("r0_v_data", v_rsp_data, BEAT_A);
        checkOutput("r0_v_last", v_rsp_last, 1'b1);
        checkOutput("r0_ie_valid", ie_rsp_valid, 1'b0);
        checkOutput("r0_rready", rready_m, 1'b1);
        tick();
        driveBeat(1'b0, 16'd0, 1'b0, 2'd0, '0);
        checkOutput("r0_v_cnt", v_outstanding, 8'd1);
        checkOutput("r0_v_ready", v_req_ready, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("r0_reissue_valid", arvalid_m, 1'b1);
        checkOutput("r0_reissue_addr", araddr_m, 64'h0000_0000_0000_D040);
        tick();
        checkOutput("r0_reissue_cnt", v_outstanding, 8'd2);

        // In-edge beat backpressured for two cycles
        ie_rsp_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            driveBeat(1'b1, 16'd1, 1'b0, 2'd0, ~BEAT_A);
            checkOutput($sformatf("bp%0d_rready", b), rready_m, 1'b0);
            checkOutput($sformatf("bp%0d_ie_valid", b), ie_rsp_valid, 1'b1);
            checkOutput($sformatf("bp%0d_ie_data", b), ie_rsp_data, ~BEAT_A);
            checkOutput($sformatf("bp%0d_v_valid", b), v_rsp_valid, 1'b0);
            tick();
        end
        ie_rsp_ready = 1'b1;
        #1;
        checkOutput("bp_release_rready", rready_m, 1'b1);
        tick();

        // Stray rid is drained and flagged without reaching either stream
        driveBeat(1'b1, 16'd5, 1'b1, 2'd0, BEAT_A);
        checkOutput("bad_rready", rready_m, 1'b1);
        checkOutput("bad_rsp_valids", {v_rsp_valid, ie_rsp_valid}, 2'b00);
        tick();
        driveBeat(1'b0, 16'd0, 1'b0, 2'd0, '0);
        checkOutput("bad_id_err", bad_id_err, 1'b1);
        checkOutput("bad_rresp_clean", rresp_err, 1'b0);
        checkOutput("bad_counts", {v_outstanding, ie_outstanding}, {8'd2, 8'd1});

        // Error response still forwarded, flag goes sticky
        driveBeat(1'b1, 16'd0, 1'b0, 2'd2, BEAT_A);
        checkOutput("resp_v_valid", v_rsp_valid, 1'b1);
        tick();
        driveBeat(1'b0, 16'd0, 1'b0, 2'd0, '0);
        checkOutput("resp_err", rresp_err, 1'b1);
        checkOutput("resp_v_cnt", v_outstanding, 8'd2);
        tick();
        checkOutput("resp_err_sticky", rresp_err, 1'b1);

        // Same-cycle AR issue and last beat on ID 1 leave the count at one
        applyStimulus(1'b0, '0, '0, 1'b1, 64'h0000_0000_0000_F000, 8'd0, 1'b1);
        checkOutput("same_ie_ready", ie_req_ready, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        driveBeat(1'b1, 16'd1, 1'b1, 2'd0, BEAT_A);
        checkOutput("same_arvalid", arvalid_m, 1'b1);
        checkOutput("same_arid", arid_m, 16'd1);
        tick();
        driveBeat(1'b0, 16'd0, 1'b0, 2'd0, '0);
        checkOutput("same_ie_cnt", ie_outstanding, 8'd1);
        checkOutput("same_arvalid_done", arvalid_m, 1'b0);
        checkOutput("final_not_idle", idle, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
